// File: rtl/seg14_pkg.sv
// Shared constants for the 14-segment scan decoder: glyph font, code values,
// digit count and FSM state type.
package seg14_pkg;

  localparam int unsigned NUM_DIGITS = 12;
  localparam int unsigned NUM_GLYPHS = 36;
  localparam logic [5:0]  CODE_BLANK = 6'd36;
  localparam logic [5:0]  CODE_UNK   = 6'd63;

  // Segment order per entry: a b c d e f | g1 g2 | h i j k l m (bit 13 = a).
  // Entry index is the character code: 0..9 digits, 10..35 letters A..Z.
  localparam logic [13:0] GLYPH [NUM_GLYPHS] = '{
    14'b111111_00_001001, 14'b011000_00_001000, 14'b110110_11_000000,
    14'b111100_01_000000, 14'b011001_11_000000, 14'b100101_10_000100,
    14'b101111_11_000000, 14'b100000_00_001010, 14'b111111_11_000000,
    14'b111101_11_000000, 14'b111011_11_000000, 14'b111100_01_010010,
    14'b100111_00_000000, 14'b111100_00_010010, 14'b100111_10_000000,
    14'b100011_10_000000, 14'b101111_01_000000, 14'b011011_11_000000,
    14'b100100_00_010010, 14'b011110_00_000000, 14'b000011_10_001100,
    14'b000111_00_000000, 14'b011011_00_101000, 14'b011011_00_100100,
    14'b111111_00_000000, 14'b110011_11_000000, 14'b111111_00_000100,
    14'b110011_11_000100, 14'b101101_11_000000, 14'b100000_00_010010,
    14'b011111_00_000000, 14'b000011_00_001001, 14'b011011_00_000101,
    14'b000000_00_101101, 14'b000000_00_101010, 14'b100100_00_001001
  };

  typedef enum logic {SYNC, CAPTURE} state_t;

  function automatic logic [3:0] onehot_idx(input logic [NUM_DIGITS-1:0] s);
    onehot_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (s[i]) onehot_idx = 4'(i);
  endfunction

endpackage

// File: rtl/seg14_glyph_decode.sv
// Combinational full-pattern match of a 14-segment glyph to a 6-bit character code.
module seg14_glyph_decode
  import seg14_pkg::*;
(
  input  logic [13:0] pattern,
  output logic [5:0]  code
);

  always_comb begin
    code = CODE_UNK;
    if (pattern == '0) code = CODE_BLANK;
    for (int unsigned i = 0; i < NUM_GLYPHS; i++)
      if (pattern == GLYPH[i]) code = 6'(i);
  end

endmodule

// File: rtl/seg14_scan_decoder.sv
// Decodes a 12-digit multiplexed 14-segment scan bus into a frame buffer of codes.
// Define SEG14_ERRCNT_EN to add the saturating err_count output.
module seg14_scan_decoder
  import seg14_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sel,
  input  logic [13:0] segm,
  input  logic [3:0]  rd_addr,
  output logic [5:0]  rd_data,
  output logic        frame_done,
  output logic        frame_unk,
  output logic        seq_err,
  output logic [7:0]  frame_count
`ifdef SEG14_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  logic [11:0] sel_q, last_sel;
  logic [13:0] segm_q;
  state_t      state, state_n;
  logic [3:0]  idx, idx_n, hot;
  logic [5:0]  code;
  logic [5:0]  shadow  [NUM_DIGITS];
  logic [5:0]  visible [NUM_DIGITS];
  logic        store, commit, err, unk;

  seg14_glyph_decode u_dec (.pattern(segm_q), .code(code));

  assign hot = onehot_idx(sel_q);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    store   = 1'b0;
    commit  = 1'b0;
    err     = 1'b0;
    if (sel_q != '0 && sel_q != last_sel) begin
      if ((sel_q & (sel_q - 12'd1)) != '0) begin
        err     = 1'b1;
        state_n = SYNC;
        idx_n   = '0;
      end else if (state == SYNC) begin
        if (hot == 4'd0) begin
          store   = 1'b1;
          idx_n   = 4'd1;
          state_n = CAPTURE;
        end
      end else if (hot == idx) begin
        store = 1'b1;
        if (idx == 4'(NUM_DIGITS - 1)) begin
          commit = 1'b1;
          idx_n  = '0;
        end else begin
          idx_n = idx + 4'd1;
        end
      end else begin
        // Out-of-order digit; a digit-0 sample doubles as the start of a new frame.
        err = 1'b1;
        if (hot == 4'd0) begin
          store = 1'b1;
          idx_n = 4'd1;
        end else begin
          state_n = SYNC;
          idx_n   = '0;
        end
      end
    end
  end

  always_comb begin
    unk = (code == CODE_UNK);
    for (int unsigned i = 0; i < NUM_DIGITS - 1; i++)
      if (shadow[i] == CODE_UNK) unk = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      segm_q      <= '0;
      last_sel    <= '0;
      frame_done  <= 1'b0;
      seq_err     <= 1'b0;
      frame_unk   <= 1'b0;
      frame_count <= '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow[i]  <= CODE_BLANK;
        visible[i] <= CODE_BLANK;
      end
    end else begin
      sel_q      <= sel;
      segm_q     <= segm;
      if (sel_q != '0) last_sel <= sel_q;
      frame_done <= commit;
      seq_err    <= err;
      if (store) shadow[hot] <= code;
      if (commit) begin
        for (int unsigned i = 0; i < NUM_DIGITS - 1; i++)
          visible[i] <= shadow[i];
        visible[NUM_DIGITS-1] <= code;
        frame_unk   <= unk;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

`ifdef SEG14_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (err && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

  always_comb begin
    rd_data = CODE_UNK;
    if (rd_addr < 4'(NUM_DIGITS)) rd_data = visible[rd_addr];
  end

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// Scoreboard bench for seg14_scan_decoder: a queue-based reference model predicts
// commits and sequence errors; a monitor checks pulses, counters and the buffer.
module tb_seg14_scan_decoder;

  localparam logic [13:0] FONT [36] = '{
    14'b111111_00_001001, 14'b011000_00_001000, 14'b110110_11_000000,
    14'b111100_01_000000, 14'b011001_11_000000, 14'b100101_10_000100,
    14'b101111_11_000000, 14'b100000_00_001010, 14'b111111_11_000000,
    14'b111101_11_000000, 14'b111011_11_000000, 14'b111100_01_010010,
    14'b100111_00_000000, 14'b111100_00_010010, 14'b100111_10_000000,
    14'b100011_10_000000, 14'b101111_01_000000, 14'b011011_11_000000,
    14'b100100_00_010010, 14'b011110_00_000000, 14'b000011_10_001100,
    14'b000111_00_000000, 14'b011011_00_101000, 14'b011011_00_100100,
    14'b111111_00_000000, 14'b110011_11_000000, 14'b111111_00_000100,
    14'b110011_11_000100, 14'b101101_11_000000, 14'b100000_00_010010,
    14'b011111_00_000000, 14'b000011_00_001001, 14'b011011_00_000101,
    14'b000000_00_101101, 14'b000000_00_101010, 14'b100100_00_001001
  };

  typedef struct packed {
    logic [31:0]      cyc;
    logic [11:0][5:0] codes;
    logic             unk;
    logic [7:0]       cnt;
  } frame_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  ecnt;
  } err_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] sel;
  logic [13:0] segm;
  logic [3:0]  rd_addr;
  logic [5:0]  rd_data;
  logic        frame_done, frame_unk, seq_err;
  logic [7:0]  frame_count;
`ifdef SEG14_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  seg14_scan_decoder dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .segm(segm), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_done(frame_done), .frame_unk(frame_unk),
    .seq_err(seq_err), .frame_count(frame_count)
`ifdef SEG14_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #20 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  frame_t fq[$];
  err_t   eq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: the partial frame is a queue whose length is the next digit expected.
  logic [5:0]  m_partial[$];
  bit          m_synced;
  logic [11:0] m_last;
  logic [7:0]  m_cnt, m_ecnt;

  function automatic logic [5:0] ref_decode(input logic [13:0] p);
    if (p == 14'h0) return 6'd36;
    for (int i = 0; i < 36; i++) if (FONT[i] == p) return 6'(i);
    return 6'd63;
  endfunction

  function automatic logic [13:0] pat_of(input logic [5:0] c);
    if (c == 6'd36) return 14'h0;
    if (c == 6'd63) return 14'h3FFF;
    return FONT[c];
  endfunction

  task automatic model_reset();
    m_partial.delete();
    m_synced = 0;
    m_last   = '0;
    m_cnt    = '0;
    m_ecnt   = '0;
  endtask

  task automatic push_err();
    err_t e;
    if (m_ecnt != 8'd255) m_ecnt++;
    e.cyc  = cyc + 2;
    e.ecnt = m_ecnt;
    eq.push_back(e);
  endtask

  task automatic model_step(input logic [11:0] s, input logic [13:0] p);
    logic [5:0] c;
    int         k;
    frame_t     f;
    c = ref_decode(p);
    if (s == '0 || s == m_last) return;
    m_last = s;
    if ($countones(s) > 1) begin
      push_err();
      m_partial.delete();
      m_synced = 0;
      return;
    end
    k = 0;
    for (int i = 0; i < 12; i++) if (s[i]) k = i;
    if (!m_synced) begin
      if (k == 0) begin
        m_partial.push_back(c);
        m_synced = 1;
      end
      return;
    end
    if (k == m_partial.size()) begin
      m_partial.push_back(c);
      if (m_partial.size() == 12) begin
        f.unk = 1'b0;
        for (int i = 0; i < 12; i++) begin
          f.codes[i] = m_partial[i];
          if (m_partial[i] == 6'd63) f.unk = 1'b1;
        end
        m_cnt++;
        f.cnt = m_cnt;
        f.cyc = cyc + 2;
        fq.push_back(f);
        m_partial.delete();
      end
    end else begin
      push_err();
      m_partial.delete();
      if (k == 0) m_partial.push_back(c);
      else m_synced = 0;
    end
  endtask

  task automatic drive(input logic [11:0] s, input logic [13:0] p);
    @(posedge clk);
    #1;
    sel  = s;
    segm = p;
    model_step(s, p);
  endtask

  task automatic scan_frame(input logic [11:0][5:0] c);
    for (int i = 0; i < 12; i++) drive(12'(1) << i, pat_of(c[i]));
  endtask

  task automatic rand_codes(output logic [11:0][5:0] c);
    for (int i = 0; i < 12; i++) c[i] = 6'($urandom_range(35));
  endtask

  // Monitor: owns rd_addr and compares everything the DUT presents each cycle.
  initial begin
    logic [11:0][5:0] cur_vis;
    logic             cur_unk;
    logic [7:0]       cur_cnt, cur_err;
    bit               exp_fd, exp_se;
    frame_t           f;
    err_t             e;
    rd_addr = '0;
    for (int i = 0; i < 12; i++) cur_vis[i] = 6'd36;
    cur_unk = 0; cur_cnt = 0; cur_err = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 12; i++) cur_vis[i] = 6'd36;
        cur_unk = 0; cur_cnt = 0; cur_err = 0;
        chk("frame_done_in_reset", 32'(frame_done), 0);
        chk("seq_err_in_reset", 32'(seq_err), 0);
      end else begin
        exp_fd = fq.size() > 0 && fq[0].cyc == cyc;
        if (frame_done || exp_fd) begin
          chk("frame_done", 32'(frame_done), 32'(exp_fd));
          if (exp_fd) begin
            f = fq.pop_front();
            cur_vis = f.codes;
            cur_unk = f.unk;
            cur_cnt = f.cnt;
          end
        end
        exp_se = eq.size() > 0 && eq[0].cyc == cyc;
        if (seq_err || exp_se) begin
          chk("seq_err", 32'(seq_err), 32'(exp_se));
          if (exp_se) begin
            e = eq.pop_front();
            cur_err = e.ecnt;
          end
        end
      end
      chk("frame_count", 32'(frame_count), 32'(cur_cnt));
      chk("frame_unk", 32'(frame_unk), 32'(cur_unk));
`ifdef SEG14_ERRCNT_EN
      chk("err_count", 32'(err_count), 32'(cur_err));
`endif
      for (int a = 0; a < 16; a++) begin
        rd_addr = 4'(a);
        #1;
        chk($sformatf("rd_data[%0d]", a), 32'(rd_data), (a < 12) ? 32'(cur_vis[a]) : 32'd63);
      end
    end
  end

  initial begin
    logic [11:0][5:0] c;
    int               r, nk;
    logic [11:0]      s;
    rst_n = 1'b0;
    sel   = '0;
    segm  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive('0, '0);

    // E S C A L E R A 2 0 2 3
    c = {6'd3, 6'd2, 6'd0, 6'd2, 6'd10, 6'd27, 6'd14, 6'd21, 6'd10, 6'd12, 6'd28, 6'd14};
    scan_frame(c);

    // Three back-to-back frames
    for (int n = 0; n < 3; n++) begin
      rand_codes(c);
      scan_frame(c);
    end

    // Two-hot select mid-frame, then a clean frame
    rand_codes(c);
    for (int i = 0; i < 5; i++) drive(12'(1) << i, pat_of(c[i]));
    drive(12'h003, FONT[7]);
    rand_codes(c);
    scan_frame(c);

    // Skipped digit, then a clean frame with idle and held-digit cycles inserted
    drive(12'h001, FONT[1]);
    drive(12'h002, FONT[2]);
    drive(12'h004, FONT[3]);
    drive(12'h010, FONT[4]);
    rand_codes(c);
    for (int i = 0; i < 12; i++) begin
      drive(12'(1) << i, pat_of(c[i]));
      if (i % 3 == 1) drive('0, FONT[9]);
      if (i % 4 == 2) drive(12'(1) << i, FONT[20]);
    end

    // Unknown glyph at digit 5
    rand_codes(c);
    c[5] = 6'd63;
    scan_frame(c);

    // Reset mid-frame at digit 6, then a full frame
    rand_codes(c);
    for (int i = 0; i < 7; i++) drive(12'(1) << i, pat_of(c[i]));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sel   = '0;
    segm  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rand_codes(c);
    scan_frame(c);

    // Randomized scan traffic
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(99);
      nk = m_synced ? m_partial.size() : 0;
      if (r < 70)      s = 12'(1) << nk;
      else if (r < 78) s = '0;
      else if (r < 86) s = m_last;
      else if (r < 92) s = 12'(1) << $urandom_range(11);
      else if (r < 96) s = (12'(1) << $urandom_range(5)) | (12'(1) << (6 + $urandom_range(5)));
      else             s = 12'h001;
      r = $urandom_range(9);
      if (r < 7)       drive(s, FONT[$urandom_range(35)]);
      else if (r == 7) drive(s, 14'h0);
      else if (r == 8) drive(s, 14'h3FFF);
      else             drive(s, 14'($urandom));
    end

    repeat (4) drive('0, '0);
    chk("frames_pending", 32'(fq.size()), 0);
    chk("errors_pending", 32'(eq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
